// File: rtl/prt_dp_pm_mem_ldr.sv
// Policy maker memory loader: ROM word / RAM byte write ports from the PM update stream.
// Optional running checksum on CHK_OUT when PRT_DP_PM_MEM_LDR_CHK_EN is defined.
module prt_dp_pm_mem_ldr #(
    parameter int P_ROM_ADR = 12,
    parameter int P_RAM_ADR = 12,
    parameter int P_IDLE_TO = 256
) (
    input  logic                 RST_IN,
    input  logic                 CLK_IN,
    input  logic                 STR_IN,
    input  logic [31:0]          DAT_IN,
    input  logic [1:0]           VLD_IN,
    output logic                 ROM_WR_OUT,
    output logic [P_ROM_ADR-1:0] ROM_ADR_OUT,
    output logic [31:0]          ROM_DAT_OUT,
    output logic                 RAM_WR_OUT,
    output logic [P_RAM_ADR-1:0] RAM_ADR_OUT,
    output logic [7:0]           RAM_DAT_OUT,
    output logic                 BUSY_OUT,
    output logic                 DONE_OUT,
    output logic                 OVF_OUT,
    output logic                 ORUN_OUT,
    output logic [31:0]          CHK_OUT
);
    localparam int IDLE_W = $clog2(P_IDLE_TO);
    localparam int WCNT_W = P_RAM_ADR - 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(P_IDLE_TO - 1);

    typedef enum logic {IDLE, LOAD} state_t;
    state_t state, nxt;

    logic [P_ROM_ADR:0]   rom_cnt;
    logic [WCNT_W-1:0]    ram_wcnt;
    logic [P_RAM_ADR-1:0] ram_bcnt;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [23:0]          ser_dat;
    logic [1:0]           ser_cnt;
    logic [31:0]          pend_dat;
    logic                 pend_vld;

    logic                 rom_wr, ram_wr, done, ovf, orun;
    logic [P_ROM_ADR-1:0] rom_adr;
    logic [31:0]          rom_dat;
    logic [P_RAM_ADR-1:0] ram_adr;
    logic [7:0]           ram_dat;

    logic active, rom_vld, ram_vld, rom_acc, ram_acc, ser_busy;
    logic to_ser, to_pend, ram_drop, ram_store, start_ser, idle_max, finish;
    logic [31:0] ser_src;

    assign active    = (state == LOAD) && !STR_IN;
    assign rom_vld   = active && VLD_IN[0];
    assign ram_vld   = active && VLD_IN[1];
    assign rom_acc   = rom_vld && !rom_cnt[P_ROM_ADR];
    assign ram_acc   = ram_vld && !ram_wcnt[WCNT_W-1];
    assign ser_busy  = (ser_cnt != 2'd0);
    // A pending word vacates exactly when the serializer is idle, so a new word may take its slot.
    assign to_ser    = ram_acc && !ser_busy && !pend_vld;
    assign to_pend   = ram_acc && (ser_busy ^ pend_vld);
    assign ram_drop  = ram_acc && ser_busy && pend_vld;
    assign ram_store = to_ser || to_pend;
    assign start_ser = !ser_busy && (pend_vld || to_ser);
    assign ser_src   = pend_vld ? pend_dat : DAT_IN;
    assign idle_max  = (idle_cnt == IDLE_MAX);

    always_comb begin
        nxt    = state;
        finish = 1'b0;
        case (state)
            IDLE: if (STR_IN) nxt = LOAD;
            LOAD: if (!STR_IN && idle_max && !ser_busy && !pend_vld) begin
                nxt    = IDLE;
                finish = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            rom_cnt  <= '0;
            ram_wcnt <= '0;
            ram_bcnt <= '0;
            idle_cnt <= '0;
            ser_dat  <= '0;
            ser_cnt  <= '0;
            pend_dat <= '0;
            pend_vld <= 1'b0;
            rom_wr   <= 1'b0;
            rom_adr  <= '0;
            rom_dat  <= '0;
            ram_wr   <= 1'b0;
            ram_adr  <= '0;
            ram_dat  <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            orun     <= 1'b0;
        end else begin
            done <= finish;
            if (STR_IN || (VLD_IN != 2'b00))
                idle_cnt <= '0;
            else if (state == LOAD && !idle_max)
                idle_cnt <= idle_cnt + IDLE_W'(1);

            if (STR_IN) begin
                rom_cnt  <= '0;
                ram_wcnt <= '0;
                ram_bcnt <= '0;
                ser_cnt  <= '0;
                pend_vld <= 1'b0;
                rom_wr   <= 1'b0;
                ram_wr   <= 1'b0;
                ovf      <= 1'b0;
                orun     <= 1'b0;
            end else begin
                rom_wr <= rom_acc;
                if (rom_acc) begin
                    rom_adr <= rom_cnt[P_ROM_ADR-1:0];
                    rom_dat <= DAT_IN;
                    rom_cnt <= rom_cnt + (P_ROM_ADR+1)'(1);
                end
                if ((rom_vld && !rom_acc) || (ram_vld && !ram_acc))
                    ovf <= 1'b1;
                if (ram_drop)
                    orun <= 1'b1;
                if (ram_store)
                    ram_wcnt <= ram_wcnt + WCNT_W'(1);

                if (to_pend) begin
                    pend_dat <= DAT_IN;
                    pend_vld <= 1'b1;
                end else if (start_ser) begin
                    pend_vld <= 1'b0;
                end

                ram_wr <= ser_busy || start_ser;
                if (ser_busy) begin
                    ram_dat  <= ser_dat[7:0];
                    ram_adr  <= ram_bcnt;
                    ram_bcnt <= ram_bcnt + P_RAM_ADR'(1);
                    ser_dat  <= {8'h00, ser_dat[23:8]};
                    ser_cnt  <= ser_cnt - 2'd1;
                end else if (start_ser) begin
                    // First byte goes straight to the port; the remaining three are held.
                    ram_dat  <= ser_src[7:0];
                    ram_adr  <= ram_bcnt;
                    ram_bcnt <= ram_bcnt + P_RAM_ADR'(1);
                    ser_dat  <= ser_src[31:8];
                    ser_cnt  <= 2'd3;
                end
            end
        end
    end

`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
    logic [31:0] chk;
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN)
            chk <= '0;
        else if (STR_IN)
            chk <= '0;
        else
            chk <= chk + (rom_acc ? DAT_IN : 32'd0) + (ram_store ? DAT_IN : 32'd0);
    end
    assign CHK_OUT = chk;
`else
    assign CHK_OUT = '0;
`endif

    assign ROM_WR_OUT  = rom_wr;
    assign ROM_ADR_OUT = rom_adr;
    assign ROM_DAT_OUT = rom_dat;
    assign RAM_WR_OUT  = ram_wr;
    assign RAM_ADR_OUT = ram_adr;
    assign RAM_DAT_OUT = ram_dat;
    assign BUSY_OUT    = (state == LOAD);
    assign DONE_OUT    = done;
    assign OVF_OUT     = ovf;
    assign ORUN_OUT    = orun;
endmodule

// File: tb/tb_prt_dp_pm_mem_ldr.sv
// Bench for prt_dp_pm_mem_ldr: directed scenarios plus random traffic against an event-schedule model.
// Honours PRT_DP_PM_MEM_LDR_CHK_EN for the expected CHK_OUT value.
module tb_prt_dp_pm_mem_ldr;
    localparam int P_ROM_ADR = 2;
    localparam int P_RAM_ADR = 4;
    localparam int P_IDLE_TO = 16;
    localparam int ROM_CAP   = 1 << P_ROM_ADR;
    localparam int RAM_WCAP  = 1 << (P_RAM_ADR - 2);

    logic                 rst, clk, str;
    logic [31:0]          dat;
    logic [1:0]           vld;
    logic                 rom_wr, ram_wr, busy, done, ovf, orun;
    logic [P_ROM_ADR-1:0] rom_adr;
    logic [31:0]          rom_dat, chk;
    logic [P_RAM_ADR-1:0] ram_adr;
    logic [7:0]           ram_dat;

    prt_dp_pm_mem_ldr #(.P_ROM_ADR(P_ROM_ADR), .P_RAM_ADR(P_RAM_ADR), .P_IDLE_TO(P_IDLE_TO)) dut (
        .RST_IN(rst), .CLK_IN(clk), .STR_IN(str), .DAT_IN(dat), .VLD_IN(vld),
        .ROM_WR_OUT(rom_wr), .ROM_ADR_OUT(rom_adr), .ROM_DAT_OUT(rom_dat),
        .RAM_WR_OUT(ram_wr), .RAM_ADR_OUT(ram_adr), .RAM_DAT_OUT(ram_dat),
        .BUSY_OUT(busy), .DONE_OUT(done), .OVF_OUT(ovf), .ORUN_OUT(orun), .CHK_OUT(chk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: expected write events keyed by the cycle they become visible.
    int          ev_rom_adr [int];
    logic [31:0] ev_rom_dat [int];
    int          ev_ram_adr [int];
    logic [31:0] ev_ram_dat [int];
    int          m_rom_adr, m_ram_adr;
    logic [31:0] m_rom_dat, m_ram_dat, m_chk;
    bit          m_busy, m_done, m_ovf, m_orun;
    int          m_rom_n, m_ram_n, m_last, m_last_start, m_last_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        ev_rom_adr.delete(); ev_rom_dat.delete();
        ev_ram_adr.delete(); ev_ram_dat.delete();
        m_rom_adr = 0; m_ram_adr = 0; m_rom_dat = '0; m_ram_dat = '0; m_chk = '0;
        m_busy = 0; m_done = 0; m_ovf = 0; m_orun = 0;
        m_rom_n = 0; m_ram_n = 0; m_last = 0; m_last_start = -100; m_last_byte = -1;
    endtask

    task automatic model_cycle(input logic s, input logic [1:0] v, input logic [31:0] d);
        int c = cyc;
        bit was_load = m_busy;
        int q[$];
        int start;
        m_done = 0;
        if (was_load && !s && c >= m_last + P_IDLE_TO && m_last_byte <= c) begin
            m_busy = 0;
            m_done = 1;
        end
        if (s) begin
            foreach (ev_ram_dat[k]) if (k > c) q.push_back(k);
            foreach (q[i]) begin ev_ram_dat.delete(q[i]); ev_ram_adr.delete(q[i]); end
            if (m_last_byte > c) m_last_byte = c;
            m_rom_n = 0; m_ram_n = 0; m_ovf = 0; m_orun = 0; m_chk = '0;
            m_last_start = -100; m_busy = 1; m_last = c;
        end else if (was_load) begin
            if (v != 2'b00) m_last = c;
            if (v[0]) begin
                if (m_rom_n < ROM_CAP) begin
                    ev_rom_adr[c+1] = m_rom_n;
                    ev_rom_dat[c+1] = d;
                    m_rom_n++;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
                    m_chk += d;
`endif
                end else m_ovf = 1;
            end
            if (v[1]) begin
                if (m_ram_n >= RAM_WCAP) m_ovf = 1;
                else if (m_last_start > c + 1) m_orun = 1;
                else begin
                    start = (c + 1 > m_last_start + 4) ? c + 1 : m_last_start + 4;
                    for (int k = 0; k < 4; k++) begin
                        ev_ram_adr[start+k] = m_ram_n * 4 + k;
                        ev_ram_dat[start+k] = (d >> (8 * k)) & 32'hFF;
                    end
                    m_ram_n++;
                    m_last_start = start;
                    m_last_byte = start + 3;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
                    m_chk += d;
`endif
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic e_rw, e_aw;
        e_rw = ev_rom_dat.exists(cyc);
        if (e_rw) begin m_rom_adr = ev_rom_adr[cyc]; m_rom_dat = ev_rom_dat[cyc]; end
        e_aw = ev_ram_dat.exists(cyc);
        if (e_aw) begin m_ram_adr = ev_ram_adr[cyc]; m_ram_dat = ev_ram_dat[cyc]; end
        check("rom_wr",  32'(rom_wr),  32'(e_rw));
        check("rom_adr", 32'(rom_adr), m_rom_adr);
        check("rom_dat", rom_dat,      m_rom_dat);
        check("ram_wr",  32'(ram_wr),  32'(e_aw));
        check("ram_adr", 32'(ram_adr), m_ram_adr);
        check("ram_dat", 32'(ram_dat), m_ram_dat);
        check("busy",    32'(busy),    32'(m_busy));
        check("done",    32'(done),    32'(m_done));
        check("ovf",     32'(ovf),     32'(m_ovf));
        check("orun",    32'(orun),    32'(m_orun));
        check("chk",     chk,          m_chk);
    endtask

    task automatic step(input logic s, input logic [1:0] v, input logic [31:0] d);
        @(posedge clk); #1;
        cyc++;
        compare_outputs();
        str = s; vld = v; dat = d;
        model_cycle(s, v, d);
    endtask

    task automatic wait_done();
        for (int i = 0; i < P_IDLE_TO + 40 && busy; i++) step(1'b0, 2'b00, '0);
        step(1'b0, 2'b00, '0);
        check("done_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_chk;
        rst = 1'b1; str = 1'b0; vld = 2'b00; dat = '0;
        model_reset();
        #2;
        compare_outputs();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // ROM words, idle timeout, checksum
        step(1, 2'b00, '0);
        step(0, 2'b01, 32'h11111111);
        step(0, 2'b01, 32'h22222222);
        step(0, 2'b01, 32'h33333333);
        step(0, 2'b00, '0);
        wait_done();
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
        exp_chk = 32'h66666666;
`else
        exp_chk = 32'h0;
`endif
        check("t1_chk", chk, exp_chk);

        // Two RAM words back-to-back
        step(1, 2'b00, '0);
        step(0, 2'b10, 32'h44332211);
        step(0, 2'b10, 32'h88776655);
        for (int i = 0; i < 9; i++) step(0, 2'b00, '0);
        check("t2_last_byte", 32'(ram_dat), 32'h88);
        wait_done();

        // Third word overruns
        step(1, 2'b00, '0);
        step(0, 2'b10, 32'hA4A3A2A1);
        step(0, 2'b10, 32'hB4B3B2B1);
        step(0, 2'b10, 32'hC4C3C2C1);
        wait_done();
        check("t3_orun_sticky", 32'(orun), 32'd1);

        // ROM overflow at capacity 4
        step(1, 2'b00, '0);
        for (int i = 0; i < 5; i++) step(0, 2'b01, 32'h1000 + i);
        step(0, 2'b00, '0);
        check("t4_ovf", 32'(ovf), 32'd1);
        wait_done();

        // Restart during byte emission
        step(1, 2'b00, '0);
        step(0, 2'b10, 32'hDDCCBBAA);
        step(0, 2'b00, '0);
        step(1, 2'b00, '0);
        step(0, 2'b00, '0);
        check("t5_ovf_clr", 32'(ovf), 32'd0);
        step(0, 2'b10, 32'h04030201);
        step(0, 2'b00, '0);
        check("t5_adr0", 32'(ram_adr), 32'd0);
        wait_done();

        // Random traffic, occasional restarts
        for (int sess = 0; sess < 8; sess++) begin
            step(1, 2'b00, '0);
            for (int i = 0; i < 30; i++) begin
                logic s;
                logic [1:0] v;
                s = ($urandom_range(0, 39) == 0);
                v = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
                step(s, v, $urandom);
            end
            wait_done();
        end

        // Asynchronous reset mid-load
        step(1, 2'b00, '0);
        step(0, 2'b11, 32'hCAFEF00D);
        step(0, 2'b00, '0);
        @(posedge clk); #1;
        cyc++;
        compare_outputs();
        str = 1'b0; vld = 2'b00;
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        step(0, 2'b11, 32'h12345678);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 2'b11, $urandom);
        step(0, 2'b00, '0);
        check("t6_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/prt_dp_pm_mem_ldr.md
Name: prt_dp_pm_mem_ldr

Overview:
Policy maker memory loader. Consumes the memory-update stream (start, 32-bit data, ROM/RAM valid) produced by the PM exchange block and turns it into write ports for the policy maker instruction ROM (32-bit words) and data RAM (8-bit bytes). It keeps the address counters, unpacks RAM words into bytes with one word of buffering, detects end of load by idle timeout, and reports overflow and overrun status.

Parameters:
P_ROM_ADR, 12, ROM word address width; ROM capacity 2^P_ROM_ADR words
P_RAM_ADR, 12, RAM byte address width (>=2); RAM capacity 2^P_RAM_ADR bytes
P_IDLE_TO, 256, idle cycles without valid input before a load is considered finished (>=2)

Ports:
RST_IN  in  1  reset; asynchronous, active-high
CLK_IN  in  1  clock
STR_IN  in  1  load start pulse
DAT_IN  in  32  load data
VLD_IN  in  2  data valid; bit 0 ROM, bit 1 RAM
ROM_WR_OUT  out  1  ROM write strobe
ROM_ADR_OUT  out  P_ROM_ADR  ROM word address
ROM_DAT_OUT  out  32  ROM write data
RAM_WR_OUT  out  1  RAM write strobe
RAM_ADR_OUT  out  P_RAM_ADR  RAM byte address
RAM_DAT_OUT  out  8  RAM write data
BUSY_OUT  out  1  load in progress; PM is held while high
DONE_OUT  out  1  one-cycle pulse at end of load
OVF_OUT  out  1  sticky: word dropped because ROM or RAM was full
ORUN_OUT  out  1  sticky: RAM word dropped because the serializer and pending register were both occupied
CHK_OUT  out  32  running checksum (see Optional Feature)

Behaviour:
- Reset: every output is 0. The FSM is in IDLE. Counters, serializer, pending register and flags are cleared.
- FSM states are IDLE and LOAD.
  - IDLE -> LOAD on STR_IN.
  - LOAD -> IDLE when the idle counter equals P_IDLE_TO-1 and the serializer and pending register are both empty. DONE_OUT is high in the cycle BUSY_OUT falls.
  - BUSY_OUT = (state == LOAD).
- STR_IN behaviour, in any state including mid-LOAD:
  - Clears the ROM and RAM address counters, the serializer, the pending register, OVF, ORUN, CHK and the idle counter.
  - Any partially emitted RAM word is abandoned.
  - VLD_IN in the same cycle as STR_IN is ignored.
- VLD_IN is ignored in IDLE.
- Idle counter:
  - Clears on any VLD_IN bit or STR_IN.
  - Otherwise increments in LOAD and saturates at P_IDLE_TO-1.
- ROM path:
  - A word with VLD_IN[0] is written 1 cycle later: ROM_WR_OUT=1, ROM_DAT_OUT=word, ROM_ADR_OUT=current count. The counter then increments.
  - Capacity: words 0..2^P_ROM_ADR-1 are accepted. Any further word is dropped (no strobe) and sets OVF. The address does not wrap.
- RAM path:
  - A word with VLD_IN[1] is accepted if the accepted RAM word count is below 2^(P_RAM_ADR-2). Otherwise it is dropped and OVF is set.
  - An accepted word loads the serializer if it is empty. Otherwise it goes to the pending register if that is empty. Otherwise it is dropped and ORUN is set.
  - The serializer emits 4 bytes on consecutive cycles, LSB first (DAT_IN[7:0] first). The first byte appears 1 cycle after VLD_IN. RAM_ADR_OUT increments by 1 per byte.
  - Pending word transfer into the serializer:
    - The pending word enters the serializer in the cycle after the last byte, so there is no gap between words.
    - A new word arriving in that same cycle is placed in pending.
- VLD_IN[0] and VLD_IN[1] asserted together are processed independently, each per its own path.
- Strobes are 0 whenever no write occurs. Data and address outputs hold their last values.

Optional Feature:
Macro PRT_DP_PM_MEM_LDR_CHK_EN.
- Defined: CHK_OUT is a 32-bit modulo-2^32 sum of every accepted ROM and RAM word. Dropped words are excluded. CHK_OUT updates 1 cycle after acceptance and is cleared by STR_IN and reset.
- Not defined: CHK_OUT is tied to 0 and no adder is built.

Test Plan:
1. STR, then ROM words 0x11111111, 0x22222222, 0x33333333 in consecutive cycles -> ROM_WR at addresses 0,1,2 with matching data, each 1 cycle after its valid. After P_IDLE_TO cycles BUSY falls with a DONE pulse. CHK=0x66666666 with the macro, 0 without.
2. STR, then RAM words 0x44332211 and 0x88776655 back-to-back -> 8 consecutive RAM_WR strobes at addresses 0..7 with data 11,22,33,44,55,66,77,88. ORUN=0.
3. STR, then three RAM words in consecutive cycles -> the third is dropped and ORUN=1. 8 bytes are written. ORUN persists until the next STR.
4. P_ROM_ADR=2: STR, then 5 ROM words -> 4 writes at addresses 0..3, the fifth produces no strobe, OVF=1.
5. STR, then 1 RAM word; STR again during byte 2 -> emission stops, the counter resets, and the next RAM word writes address 0. Flags and CHK are cleared.
6. Assert RST_IN mid-LOAD -> all outputs 0 immediately. VLD_IN is ignored until the next STR.
